stream_arb: RTL and testbench

- Packet-level round-robin arbiter that shares the single AXI-Stream S2MM input of the DMA between N_SRC stream sources, such as multiple stream_gen instances.
- Sits between the sources and the system block's stream_* port, in the axi_aclk domain.
- A grant is held from the first beat of a packet until its tlast beat is accepted, so packets are never interleaved.
- Emits a per-packet done pulse and the granted source ID for software and irq use.

---
 rtl/stream_arb_pkg.sv | 29 ++
 rtl/rr_select.sv | 22 ++
 rtl/stream_arb.sv | 129 ++++++++++++
 tb/tb_stream_arb.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_arb_pkg.sv
// Shared types, constants and the round-robin pick function used by stream_arb and rr_select.
package stream_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int CNT_W   = 16;
  localparam int MAX_SRC = 16;

  // First set bit of req searching upward from last+1, wrapping modulo n.
  function automatic int rr_pick(input logic [MAX_SRC-1:0] req, input int last, input int n);
    int   idx;
    int   j;
    logic found;
    idx   = 0;
    found = 1'b0;
    for (int k = 1; k <= MAX_SRC; k++) begin
      j = (last + k) % n;
      if (k <= n && !found && req[j]) begin
        idx   = j;
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin priority picker: next requester after last, zero latency, no flow control.
module rr_select
  import stream_arb_pkg::*;
#(
  parameter int N_SRC = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_SRC-1:0] req_i,
  input  logic [ID_W-1:0]  last_i,
  output logic             vld_o,
  output logic [ID_W-1:0]  idx_o
);

  logic [MAX_SRC-1:0] req_ext;
  int                 pick;

  assign req_ext = MAX_SRC'(req_i);
  assign pick    = rr_pick(req_ext, int'(last_i), N_SRC);
  assign vld_o   = |req_i;
  assign idx_o   = ID_W'(pick);

endmodule

// File: rtl/stream_arb.sv
// Packet-level round-robin AXI-Stream arbiter: 1-cycle grant, grant held to tlast, m_tready passed to the granted source only.
// Define STREAM_ARB_PKT_CNT_EN to add per-source accepted-packet counters (pkt_cnt, cnt_clr).
module stream_arb
  import stream_arb_pkg::*;
#(
  parameter int N_SRC  = 4,
  parameter int DATA_W = 32,
  parameter int ID_W   = 2
) (
  input  logic                      clk,
  input  logic                      aresetn,
  input  logic [N_SRC-1:0]          src_en,
  input  logic [N_SRC*DATA_W-1:0]   s_tdata,
  input  logic [N_SRC*DATA_W/8-1:0] s_tkeep,
  input  logic [N_SRC-1:0]          s_tlast,
  input  logic [N_SRC-1:0]          s_tvalid,
  output logic [N_SRC-1:0]          s_tready,
  output logic [DATA_W-1:0]         m_tdata,
  output logic [DATA_W/8-1:0]       m_tkeep,
  output logic                      m_tlast,
  output logic                      m_tvalid,
  input  logic                      m_tready,
  output logic                      busy,
  output logic [ID_W-1:0]           grant_id,
  output logic                      pkt_done
`ifdef STREAM_ARB_PKT_CNT_EN
  ,
  input  logic                      cnt_clr,
  output logic [N_SRC*CNT_W-1:0]    pkt_cnt
`endif
);

  localparam int KEEP_W = DATA_W / 8;

  state_t          state_q;
  logic [ID_W-1:0] grant_q;
  logic [ID_W-1:0] last_q;
  logic            pkt_done_q;
  logic            pick_vld;
  logic [ID_W-1:0] pick_idx;
  logic            beat_acc;
  logic            last_acc;

  rr_select #(
    .N_SRC (N_SRC),
    .ID_W  (ID_W)
  ) u_rr_select (
    .req_i  (s_tvalid & src_en),
    .last_i (last_q),
    .vld_o  (pick_vld),
    .idx_o  (pick_idx)
  );

  // Outputs are forced to zero outside BUSY so reset and idle look identical downstream.
  always_comb begin
    m_tdata  = '0;
    m_tkeep  = '0;
    m_tlast  = 1'b0;
    m_tvalid = 1'b0;
    s_tready = '0;
    if (state_q == BUSY) begin
      m_tdata            = s_tdata[grant_q*DATA_W +: DATA_W];
      m_tkeep            = s_tkeep[grant_q*KEEP_W +: KEEP_W];
      m_tlast            = s_tlast[grant_q];
      m_tvalid           = s_tvalid[grant_q];
      s_tready[grant_q]  = m_tready;
    end
  end

  assign beat_acc = m_tvalid & m_tready;
  assign last_acc = beat_acc & m_tlast;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      last_q     <= ID_W'(N_SRC - 1);
      pkt_done_q <= 1'b0;
    end else begin
      pkt_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            grant_q <= pick_idx;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (last_acc) begin
            pkt_done_q <= 1'b1;
            last_q     <= grant_q;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = (state_q == BUSY);
  assign grant_id = grant_q;
  assign pkt_done = pkt_done_q;

`ifdef STREAM_ARB_PKT_CNT_EN
  logic [N_SRC*CNT_W-1:0] cnt_q;
  logic [N_SRC*CNT_W-1:0] cnt_d;

  // Clear has priority over a same-cycle increment; counters wrap naturally.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (last_acc) begin
      cnt_d[grant_q*CNT_W +: CNT_W] = cnt_q[grant_q*CNT_W +: CNT_W] + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign pkt_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_stream_arb.sv
// Randomized scoreboard bench for stream_arb: packet-order model, beat monitor, directed corner cases.
module tb_stream_arb;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int KW = DW / 8;

  logic            clk = 1'b0;
  logic            aresetn;
  logic [N-1:0]    src_en;
  logic [N*DW-1:0] s_tdata;
  logic [N*KW-1:0] s_tkeep;
  logic [N-1:0]    s_tlast;
  logic [N-1:0]    s_tvalid;
  logic [N-1:0]    s_tready;
  logic [DW-1:0]   m_tdata;
  logic [KW-1:0]   m_tkeep;
  logic            m_tlast;
  logic            m_tvalid;
  logic            m_tready;
  logic            busy;
  logic [1:0]      grant_id;
  logic            pkt_done;
`ifdef STREAM_ARB_PKT_CNT_EN
  logic            cnt_clr;
  logic [N*16-1:0] pkt_cnt;
`endif

  stream_arb #(.N_SRC(N), .DATA_W(DW), .ID_W(2)) dut (
    .clk      (clk),
    .aresetn  (aresetn),
    .src_en   (src_en),
    .s_tdata  (s_tdata),
    .s_tkeep  (s_tkeep),
    .s_tlast  (s_tlast),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .m_tdata  (m_tdata),
    .m_tkeep  (m_tkeep),
    .m_tlast  (m_tlast),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .busy     (busy),
    .grant_id (grant_id),
    .pkt_done (pkt_done)
`ifdef STREAM_ARB_PKT_CNT_EN
    ,
    .cnt_clr  (cnt_clr),
    .pkt_cnt  (pkt_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
    int          src;
  } beat_t;

  beat_t    src_q[N][$];
  beat_t    exp_q[$];
  int       done_cyc[$];
  int       errors = 0;
  int       checks = 0;
  int       model_last = N - 1;
  int       tready_mode = 0;
  bit       gap_en = 1'b0;
  int       cyc = 0;
  logic [N-1:0] mid = '0;
  logic [N-1:0] hs;
  logic     prev_last = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic add_pkt(input int s, input int len, input bit fixed, input logic [31:0] base);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.d   = fixed ? base + 32'(i) : $urandom;
      b.k   = fixed ? 4'hF : 4'($urandom_range(0, 15));
      b.l   = (i == len - 1);
      b.src = s;
      src_q[s].push_back(b);
    end
  endtask

  // Reference: every enabled source with queued packets requests; winner is the
  // next one after the previous winner, and each packet is delivered whole.
  task automatic plan(input logic [N-1:0] en);
    beat_t cp[N][$];
    beat_t b;
    int    pick;
    bit    found;
    for (int i = 0; i < N; i++) cp[i] = src_q[i];
    while (1) begin
      found = 1'b0;
      pick  = 0;
      for (int k = 1; k <= N; k++) begin
        int j;
        j = (model_last + k) % N;
        if (!found && en[j] && cp[j].size() > 0) begin
          found = 1'b1;
          pick  = j;
        end
      end
      if (!found) break;
      do begin
        b = cp[pick].pop_front();
        exp_q.push_back(b);
      end while (!b.l);
      model_last = pick;
    end
  endtask

  // Source driver: hold valid until accepted; optional gaps only inside a packet.
  initial begin
    forever begin
      @(negedge clk);
      hs = s_tvalid & s_tready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        bit keep;
        beat_t b;
        keep = s_tvalid[i] && !hs[i];
        if (hs[i] && src_q[i].size() > 0) begin
          b = src_q[i].pop_front();
          mid[i] = !b.l;
        end
        if (src_q[i].size() > 0 && (!mid[i] || keep || !gap_en || $urandom_range(0, 3) != 0)) begin
          s_tvalid[i]        = 1'b1;
          s_tdata[i*DW +: DW] = src_q[i][0].d;
          s_tkeep[i*KW +: KW] = src_q[i][0].k;
          s_tlast[i]         = src_q[i][0].l;
        end else begin
          s_tvalid[i] = 1'b0;
          s_tlast[i]  = 1'b0;
        end
      end
      case (tready_mode)
        0:       m_tready = 1'b1;
        1:       m_tready = 1'($urandom_range(0, 1));
        default: m_tready = ~m_tready;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every accepted beat.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (aresetn) begin
        logic [N-1:0] exp_tr;
        if (pkt_done) done_cyc.push_back(cyc);
        if (pkt_done || prev_last) check("pkt_done", 64'(pkt_done), 64'(prev_last));
        if (busy || s_tready != '0) begin
          exp_tr = '0;
          if (exp_q.size() > 0 && m_tready) exp_tr[exp_q[0].src] = 1'b1;
          check("s_tready", 64'(s_tready), 64'(exp_tr));
        end
        prev_last = m_tvalid & m_tready & m_tlast;
        if (m_tvalid && m_tready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL beat: unexpected beat %0h from grant %0d, expected none", m_tdata, grant_id);
          end else begin
            beat_t b;
            b = exp_q.pop_front();
            check("m_tdata", 64'(m_tdata), 64'(b.d));
            check("m_tkeep", 64'(m_tkeep), 64'(b.k));
            check("m_tlast", 64'(m_tlast), 64'(b.l));
            check("grant_id", 64'(grant_id), 64'(b.src));
          end
        end
      end else begin
        prev_last = 1'b0;
      end
    end
  end

  task automatic drain(input string name);
    for (int c = 0; c < 3000 && exp_q.size() > 0; c++) @(negedge clk);
    check(name, 64'(exp_q.size()), 64'd0);
    repeat (3) @(negedge clk);
    for (int i = 0; i < N; i++) src_q[i].delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_m_tvalid"}, 64'(m_tvalid), 64'd0);
    check({tag, "_m_tdata"},  64'(m_tdata),  64'd0);
    check({tag, "_m_tkeep"},  64'(m_tkeep),  64'd0);
    check({tag, "_m_tlast"},  64'(m_tlast),  64'd0);
    check({tag, "_s_tready"}, 64'(s_tready), 64'd0);
    check({tag, "_busy"},     64'(busy),     64'd0);
    check({tag, "_grant_id"}, 64'(grant_id), 64'd0);
    check({tag, "_pkt_done"}, 64'(pkt_done), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    aresetn  = 1'b0;
    src_en   = '0;
    s_tdata  = '0;
    s_tkeep  = '0;
    s_tlast  = '0;
    s_tvalid = '0;
    m_tready = 1'b1;
`ifdef STREAM_ARB_PKT_CNT_EN
    cnt_clr  = 1'b0;
`endif
    #12;
    check_idle_outputs("reset");
    @(negedge clk);
    aresetn = 1'b1;
    repeat (2) @(negedge clk);

    // Round-robin order from reset: 0,1,2,3,0 with a packet every 5 cycles.
    tready_mode = 0;
    gap_en      = 1'b0;
    src_en      = 4'b1111;
    add_pkt(0, 4, 1'b0, 0);
    add_pkt(0, 4, 1'b0, 0);
    for (int s = 1; s < N; s++) add_pkt(s, 4, 1'b0, 0);
    plan(src_en);
    done_cyc.delete();
    drain("rr_drain");
    check("rr_done_count", 64'(done_cyc.size()), 64'd5);
    for (int k = 1; k < done_cyc.size(); k++)
      check("rr_done_period", 64'(done_cyc[k] - done_cyc[k-1]), 64'd5);

    // Backpressure on a single source-2 packet.
    tready_mode = 2;
    add_pkt(2, 4, 1'b1, 32'hA0);
    plan(src_en);
    drain("bp_drain");

    // Mask with single-beat packets: only 0 and 2 may be served.
    tready_mode = 0;
    src_en      = 4'b0101;
    for (int s = 0; s < N; s++) for (int p = 0; p < 3; p++) add_pkt(s, 1, 1'b0, 0);
    plan(src_en);
    drain("mask_drain");

    // Disable source 0 mid-packet: its current packet completes, the next is never granted.
    src_en = 4'b0001;
    add_pkt(0, 4, 1'b0, 0);
    plan(src_en);
    add_pkt(0, 4, 1'b0, 0);
    for (int c = 0; c < 50 && !(m_tvalid && m_tready); c++) @(negedge clk);
    src_en = 4'b0000;
    for (int c = 0; c < 100 && exp_q.size() > 0; c++) @(negedge clk);
    repeat (10) @(negedge clk);
    drain("en_clear_drain");

    // Randomized phases.
    for (int p = 0; p < 8; p++) begin
      tready_mode = $urandom_range(0, 1);
      gap_en      = 1'($urandom_range(0, 1));
      src_en      = 4'($urandom_range(1, 15));
      for (int s = 0; s < N; s++)
        for (int k = 0; k < int'($urandom_range(0, 3)); k++) add_pkt(s, $urandom_range(1, 4), 1'b0, 0);
      plan(src_en);
      drain("rand_drain");
    end

    // Reset during the second beat of a source-1 packet.
    tready_mode = 0;
    gap_en      = 1'b0;
    src_en      = 4'b1111;
    for (int s = 0; s < N; s++) begin
      add_pkt(s, 4, 1'b1, 32'h100 * 32'(s));
      add_pkt(s, 4, 1'b1, 32'h100 * 32'(s) + 32'h10);
    end
    plan(src_en);
    begin
      bit hit;
      hit = 1'b0;
      for (int c = 0; c < 200 && !hit; c++) begin
        @(negedge clk);
        hit = m_tvalid && grant_id == 2'd1 && m_tdata == 32'h101;
      end
      check("reset_trigger_seen", 64'(hit), 64'd1);
    end
    aresetn = 1'b0;
    #1;
    check_idle_outputs("midpkt_reset");
    exp_q.delete();
    for (int i = 0; i < N; i++) src_q[i].delete();
    mid        = '0;
    s_tvalid   = '0;
    model_last = N - 1;
    repeat (3) @(negedge clk);
    aresetn = 1'b1;
    for (int s = N - 1; s >= 0; s--) add_pkt(s, 2, 1'b0, 0);
    plan(src_en);
    drain("post_reset_drain");

`ifdef STREAM_ARB_PKT_CNT_EN
    // Counters: clear wins over the increment on the 2nd tlast.
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    @(negedge clk);
    check("cnt_after_clr", 64'(pkt_cnt), 64'd0);
    src_en = 4'b1000;
    for (int p = 0; p < 3; p++) add_pkt(3, 1, 1'b0, 0);
    plan(src_en);
    begin
      int n;
      n = 0;
      for (int c = 0; c < 200 && (exp_q.size() > 0 || cnt_clr); c++) begin
        @(negedge clk);
        cnt_clr = 1'b0;
        if (m_tvalid && m_tready && m_tlast) begin
          n++;
          if (n == 2) cnt_clr = 1'b1;
        end
      end
      cnt_clr = 1'b0;
    end
    drain("cnt_drain");
    check("pkt_cnt3", 64'(pkt_cnt[3*16 +: 16]), 64'd1);
    check("pkt_cnt_others", 64'(pkt_cnt[0 +: 48]), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
